clk_src_switch_n: RTL
=====================

# clk_src_switch_n

Parametrised N-source glitch-free clock-source switch for the single-clock domain. It selects one of `N_SRC` clock-level signals, each generated synchronously to `clk` (for example by divided-clock counters), and forwards it on `out_lvl`. A source change is break-before-make: the current source is released only while it is low, a programmable dead time follows, and the new source is granted only while it is low. The result is that `out_lvl` never shows a truncated high phase. It generalises the two-source select/feedback switch to N sources, adds a valid/ready request handshake, dead-time insertion, invalid-select rejection and a drain timeout. It sits between the clock-enable/divider generators and the downstream gated logic.

## Interface
- `N_SRC`, default 4: number of sources, at least 2.
- `SEL_W`, default `$clog2(N_SRC)`: select width.
- `DEAD_CYC`, default 2: idle cycles between break and make; 0 is legal.
- `RST_SRC`, default 0: source armed after reset.
- `DRAIN_TMO`, default 64: maximum cycles spent waiting for the current source to go low.
- `clk`, in, 1: the single clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `src_lvl`, in, `N_SRC`: source levels, synchronous to `clk`.
- `sel_req`, in, `SEL_W`: requested source.
- `sel_valid`, in, 1: request valid.
- `sel_ready`, out, 1: request can be accepted.
- `out_lvl`, out, 1: selected level, registered.
- `out_en`, out, 1: a source is currently granted.
- `active_sel`, out, `SEL_W`: granted (or armed) source index.
- `busy`, out, 1: a switch is in progress.
- `err_sel`, out, 1: one-cycle pulse when a request has `sel_req >= N_SRC`.
- `tmo`, out, 1: one-cycle pulse when a drain timeout occurs.

## Operation
- The FSM has four states: RUN, DRAIN, DEAD, ARM. Registers: `grant`, `active`, `target`, a dead-time counter and a timeout counter.
- `out_lvl <= grant & src_lvl[active]` every cycle. `out_en = grant`.
- `sel_ready = (state == RUN) & ~rst`. `busy = (state != RUN)`.
- Accept occurs when `sel_valid & sel_ready`. Three cases:
  - `sel_req >= N_SRC`: pulse `err_sel`, stay in RUN.
  - `sel_req == active`: no-op, stay in RUN.
  - Otherwise: `target <= sel_req`, go to DRAIN, clear the timeout counter.
- DRAIN:
  - When `src_lvl[active] == 0`, set `grant <= 0`.
  - If `DEAD_CYC > 0`, go to DEAD with the counter loaded to `DEAD_CYC`; otherwise go to ARM.
  - When the timeout counter reaches `DRAIN_TMO-1` with the source still high: force `grant <= 0`, pulse `tmo`, then take the same next-state path. The counter saturates.
- DEAD: decrement the counter each cycle. Leave for ARM after exactly `DEAD_CYC` cycles in DEAD.
- ARM: when `src_lvl[target] == 0`, set `active <= target`, `grant <= 1`, go to RUN. ARM has no timeout; a stuck-high target keeps `busy` asserted until reset.
- Reset (synchronous; takes priority over everything, including mid-switch):
  - State ARM, `target = active = RST_SRC`.
  - `grant = 0`, counters cleared.
  - Next-cycle outputs: `out_lvl = 0`, `out_en = 0`, `sel_ready = 0`, `busy = 1`, `err_sel = 0`, `tmo = 0`, `active_sel = RST_SRC`.
- `active_sel` shows `active`. It changes only on the make edge and on reset.

## Timing
- Level latency: `out_lvl` at cycle t+1 equals `src_lvl[active]` at cycle t while granted.
- Accept at t: DRAIN at t+1, `sel_ready` low from t+1.
- Break: the first DRAIN cycle c that samples the source low gives `grant = 0` at c+1. `out_lvl` is already 0 at c+1 and remains 0.
- Make: an ARM cycle a that samples the target low gives `grant = 1` and RUN at a+1. `out_lvl` is 0 at a+1 and follows the new source from a+2. The first high phase passed through is therefore complete.
- Minimum `out_lvl` low gap across a switch: `DEAD_CYC + 2` cycles.
- Switch duration when sources are already low: 1 (DRAIN) + `DEAD_CYC` + 1 (ARM) cycles of `busy`.
- `err_sel` and `tmo` assert in the cycle after the triggering event, for one cycle only.

## Test plan
Common setup: `N_SRC=5`, `DEAD_CYC=2`, `DRAIN_TMO=16`. Sources: src0 toggles every cycle, src1 period 4, src2 period 8, src3 period 2, src4 held high.

- **Reset:** hold `rst` for 3 cycles with src0 high at release.
  - `out_en=0`, `busy=1` until src0 is sampled low.
  - Then `out_en=1`, `active_sel=0`.
  - `out_lvl` equals src0 delayed 1 cycle.
- **Switch 0→2:** request 2.
  - `busy` high for at least 4 cycles.
  - `out_lvl` low for at least 4 cycles.
  - Every `out_lvl` high phase is exactly 1 cycle before the switch and exactly 4 cycles after it.
  - `active_sel=2`.
- **Same select:** request 2 while `active=2`.
  - Accepted in one cycle.
  - `busy` stays 0; `out_lvl` is uninterrupted.
- **Invalid select:** `sel_req=7`.
  - `err_sel` pulses for 1 cycle.
  - `active_sel` and `out_lvl` are unchanged.
- **Drain timeout:**
  - Switch to src3, then force src3 high and request 0.
  - `tmo` pulses after 16 DRAIN cycles, `grant` drops.
  - The switch then completes to src0 after 2 dead cycles.
- **Reset mid-switch:** assert `rst` during DEAD on a 0→1 switch.
  - Next cycle: `out_lvl=0`, `out_en=0`.
  - Recovery re-arms src0, not src1.

Source files
------------

// File: rtl/clk_src_switch_n.sv
// N-source glitch-free clock-level switch: break-before-make with dead time,
// valid/ready select handshake, invalid-select rejection and drain timeout.
module clk_src_switch_n #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned SEL_W     = $clog2(N_SRC),
  parameter int unsigned DEAD_CYC  = 2,
  parameter int unsigned RST_SRC   = 0,
  parameter int unsigned DRAIN_TMO = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_lvl,
  input  logic [SEL_W-1:0] sel_req,
  input  logic             sel_valid,
  output logic             sel_ready,
  output logic             out_lvl,
  output logic             out_en,
  output logic [SEL_W-1:0] active_sel,
  output logic             busy,
  output logic             err_sel,
  output logic             tmo
);

  localparam int unsigned DEAD_W = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam int unsigned TMO_W  = (DRAIN_TMO > 1) ? $clog2(DRAIN_TMO) : 1;
  localparam int unsigned SEL_W1 = SEL_W + 1;

  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DRAIN_TMO - 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC);
  localparam logic [SEL_W:0]    N_SRC_V   = SEL_W1'(N_SRC);
  localparam logic [SEL_W-1:0]  RST_SEL   = SEL_W'(RST_SRC);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DEAD  = 2'd2,
    S_ARM   = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_grant;
  logic [SEL_W-1:0]   r_active;
  logic [SEL_W-1:0]   r_target;
  logic [DEAD_W-1:0]  r_dead_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_out_lvl;
  logic               r_err_sel;
  logic               r_tmo;

  state_t             w_state_nxt;
  logic               w_grant_nxt;
  logic [SEL_W-1:0]   w_active_nxt;
  logic [SEL_W-1:0]   w_target_nxt;
  logic [DEAD_W-1:0]  w_dead_nxt;
  logic [TMO_W-1:0]   w_tmo_cnt_nxt;
  logic               w_err_nxt;
  logic               w_tmo_nxt;

  logic               w_cur_lvl;
  logic               w_tgt_lvl;
  logic               w_accept;
  logic               w_sel_bad;
  logic               w_tmo_hit;

  assign w_cur_lvl = src_lvl[r_active];
  assign w_tgt_lvl = src_lvl[r_target];
  assign w_accept  = sel_valid & sel_ready;
  assign w_sel_bad = ({1'b0, sel_req} >= N_SRC_V);
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

  assign sel_ready  = (r_state == S_RUN) & ~rst;
  assign busy       = (r_state != S_RUN);
  assign out_lvl    = r_out_lvl;
  assign out_en     = r_grant;
  assign active_sel = r_active;
  assign err_sel    = r_err_sel;
  assign tmo        = r_tmo;

  // Next-state and register-update logic for the switch sequence
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_active_nxt  = r_active;
    w_target_nxt  = r_target;
    w_dead_nxt    = r_dead_cnt;
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_err_nxt     = 1'b0;
    w_tmo_nxt     = 1'b0;

    case (r_state)
      S_RUN: begin
        if (w_accept) begin
          if (w_sel_bad) begin
            w_err_nxt = 1'b1;
          end else if (sel_req != r_active) begin
            w_target_nxt  = sel_req;
            w_tmo_cnt_nxt = '0;
            w_state_nxt   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Release only on a low level, or forcibly once the drain budget is spent
        if (!w_cur_lvl || w_tmo_hit) begin
          w_grant_nxt = 1'b0;
          w_tmo_nxt   = w_cur_lvl;
          if (DEAD_CYC > 0) begin
            w_dead_nxt  = DEAD_LOAD;
            w_state_nxt = S_DEAD;
          end else begin
            w_state_nxt = S_ARM;
          end
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end
      S_DEAD: begin
        w_dead_nxt = r_dead_cnt - DEAD_W'(1);
        if (r_dead_cnt <= DEAD_W'(1)) begin
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        // Grant the new source only while it is low so its first high phase is whole
        if (!w_tgt_lvl) begin
          w_active_nxt = r_target;
          w_grant_nxt  = 1'b1;
          w_state_nxt  = S_RUN;
        end
      end
      default: w_state_nxt = S_ARM;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_ARM;
      r_grant    <= 1'b0;
      r_active   <= RST_SEL;
      r_target   <= RST_SEL;
      r_dead_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_out_lvl  <= 1'b0;
      r_err_sel  <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_active   <= w_active_nxt;
      r_target   <= w_target_nxt;
      r_dead_cnt <= w_dead_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_out_lvl  <= r_grant & w_cur_lvl;
      r_err_sel  <= w_err_nxt;
      r_tmo      <= w_tmo_nxt;
    end
  end

endmodule
